// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one bit per cycle.
// Produces a four-digit packed BCD word for the seven-segment display.
// Optional feature macro: BCD_SAT_OVF_EN. When defined, inputs above 9999
// saturate bcd to 16'h9999 and raise ovf. When undefined, the thousands carry
// is discarded and ovf is constant 0.
module bin_to_bcd_seq #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             ready,
    output logic             done,
    output logic [15:0]      bcd,
    output logic             ovf
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [BIN_W-1:0] shreg;
    logic [15:0]      acc;
    logic [CNT_W-1:0] cnt;

    logic [11:0]      low_adj;
    logic [2:0]       th_adj;
    logic [15:0]      acc_nxt;
    logic [15:0]      result;

`ifdef BCD_SAT_OVF_EN
    logic [BIN_W-1:0] bin_lat;
    logic             too_big;
`endif

    // Add-3 correction on every digit, then shift in the next binary MSB.
    // Only the low three bits of the thousands digit survive the shift, so the
    // carry out of the thousands digit is dropped here (value mod 10000).
    always_comb begin
        low_adj = 12'h000;
        for (int i = 0; i < 3; i++) begin
            if (acc[i*4 +: 4] >= 4'd5)
                low_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
            else
                low_adj[i*4 +: 4] = acc[i*4 +: 4];
        end
        th_adj  = (acc[15:12] >= 4'd5) ? acc[14:12] + 3'd3 : acc[14:12];
        acc_nxt = {th_adj, low_adj, shreg[BIN_W-1]};
    end

`ifdef BCD_SAT_OVF_EN
    // Overflow is judged on the latched input, not on the wrapped accumulator.
    always_comb begin
        too_big = (32'(bin_lat) > 32'd9999);
        result  = too_big ? 16'h9999 : acc_nxt;
    end
`else
    // Without saturation the wrapped accumulator is published directly.
    always_comb begin
        result = acc_nxt;
    end
    assign ovf = 1'b0;
`endif

    // Control FSM with registered outputs; bcd/ovf only move on the final shift.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            shreg <= '0;
            acc   <= 16'h0000;
            cnt   <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
            bcd   <= 16'h0000;
`ifdef BCD_SAT_OVF_EN
            bin_lat <= '0;
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shreg <= bin;
                        acc   <= 16'h0000;
                        cnt   <= CNT_W'(BIN_W);
                        ready <= 1'b0;
                        state <= SHIFT;
`ifdef BCD_SAT_OVF_EN
                        bin_lat <= bin;
`endif
                    end else begin
                        ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    acc   <= acc_nxt;
                    shreg <= {shreg[BIN_W-2:0], 1'b0};
                    cnt   <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        bcd   <= result;
                        done  <= 1'b1;
                        state <= DONE;
`ifdef BCD_SAT_OVF_EN
                        ovf <= too_big;
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
